ser_word_rx: RTL and testbench

Framed serial word receiver for the team's 1-bit data/vld link. Input bits arrive LSB-first, one per clk while the link valid is high. The block assembles each DW-bit word into a holding register and offers it on a ready/valid parallel interface. It flags short frames and overruns and sits at the receive end of the link, feeding downstream parallel logic.

---
 rtl/ser_link_pkg.sv | 25 ++
 rtl/ser_word_rx_if.sv | 28 ++
 rtl/ser_rx_hold.sv | 41 ++++
 rtl/ser_word_rx.sv | 139 +++++++++++++
 tb/tb_ser_word_rx.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/ser_link_pkg.sv
// Shared definitions for the 1-bit data/vld serial link: FSM state encoding,
// default word width and the parity convention shared with the transmitter.
package ser_link_pkg;

  localparam int DEFAULT_DW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  typedef enum logic {
    PARITY_EVEN = 1'b0,
    PARITY_ODD  = 1'b1
  } parity_t;

  localparam parity_t LINK_PARITY = PARITY_EVEN;

  // Parity bit a transmitter appends to a word (zero-extended to 16 bits).
  function automatic logic parity_of(input logic [15:0] word, input parity_t kind);
    return (^word) ^ (kind == PARITY_ODD);
  endfunction

endpackage

// File: rtl/ser_word_rx_if.sv
// Serial-in / parallel-out bundle of ser_word_rx; slave is the receiver side,
// master is the side driving the link and consuming words.
interface ser_word_rx_if
  import ser_link_pkg::*;
#(
  parameter int DW = DEFAULT_DW
);

  logic          ser_data;
  logic          ser_vld;
  logic          rx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          overrun;
  logic          par_err;

  modport slave (
    input  ser_data, ser_vld, rx_ready,
    output rx_data, rx_valid, frame_err, overrun, par_err
  );

  modport master (
    output ser_data, ser_vld, rx_ready,
    input  rx_data, rx_valid, frame_err, overrun, par_err
  );

endinterface

// File: rtl/ser_rx_hold.sv
// Holding register for completed words with a ready/valid handshake; a word
// finishing while the register is full and not being consumed is dropped.
module ser_rx_hold
  import ser_link_pkg::*;
#(
  parameter int DW = DEFAULT_DW
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          word_done,
  input  logic [DW-1:0] word_in,
  input  logic          rx_ready,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  output logic          overrun
);

  logic accept;

  // A consume in the same cycle frees the register for the incoming word.
  assign accept = word_done && (!rx_valid || rx_ready);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= word_done && rx_valid && !rx_ready;
      if (accept) begin
        rx_data  <= word_in;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ser_word_rx.sv
// Framed serial word receiver: LSB-first bits assembled into DW-bit words.
// Optional trailing even-parity bit when PARITY_CHK_EN is defined.
module ser_word_rx
  import ser_link_pkg::*;
#(
  parameter int DW = DEFAULT_DW
) (
  input  logic         clk,
  input  logic         n_rst,
  ser_word_rx_if.slave bus
);

  localparam int CW = $clog2(DW + 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DW-1:0] shift, shift_n;
  logic [DW-1:0] word_in;
  logic          word_done;
  logic          frame_err_n, frame_err_q;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          overrun;
`ifdef PARITY_CHK_EN
  logic          par_err_n, par_err_q;
`endif

  // NOTE: the shift register is reset like the rest of the datapath so a
  // frame cut short by reset leaves no stale bits behind.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      shift       <= '0;
      frame_err_q <= 1'b0;
`ifdef PARITY_CHK_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      shift       <= shift_n;
      frame_err_q <= frame_err_n;
`ifdef PARITY_CHK_EN
      par_err_q   <= par_err_n;
`endif
    end
  end

  // NOTE: every signal written here gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    shift_n     = shift;
    word_done   = 1'b0;
    frame_err_n = 1'b0;
`ifdef PARITY_CHK_EN
    par_err_n   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (bus.ser_vld) begin
          shift_n    = '0;
          shift_n[0] = bus.ser_data;
          cnt_n      = CW'(1);
          state_n    = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.ser_vld) begin
          for (int i = 0; i < DW; i++) begin
            if (cnt == CW'(i)) shift_n[i] = bus.ser_data;
          end
          if (cnt == CW'(DW - 1)) begin
            cnt_n = '0;
`ifdef PARITY_CHK_EN
            state_n = PAR;
`else
            word_done = 1'b1;
            state_n   = IDLE;
`endif
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end else begin
          frame_err_n = 1'b1;
          cnt_n       = '0;
          state_n     = IDLE;
        end
      end
`ifdef PARITY_CHK_EN
      PAR: begin
        cnt_n   = '0;
        state_n = IDLE;
        if (bus.ser_vld) begin
          if (parity_of(16'(shift), LINK_PARITY) == bus.ser_data) word_done = 1'b1;
          else                                                    par_err_n = 1'b1;
        end else begin
          frame_err_n = 1'b1;
        end
      end
`endif
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  // Without parity the word completes on the edge sampling its last bit.
`ifdef PARITY_CHK_EN
  assign word_in = shift;
`else
  assign word_in = shift_n;
`endif

  ser_rx_hold #(.DW(DW)) u_hold (
    .clk       (clk),
    .n_rst     (n_rst),
    .word_done (word_done),
    .word_in   (word_in),
    .rx_ready  (bus.rx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .overrun   (overrun)
  );

  assign bus.rx_data   = rx_data;
  assign bus.rx_valid  = rx_valid;
  assign bus.overrun   = overrun;
  assign bus.frame_err = frame_err_q;
`ifdef PARITY_CHK_EN
  assign bus.par_err   = par_err_q;
`else
  assign bus.par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ser_word_rx.sv
// Bench for ser_word_rx (DW=4): directed scenarios plus random traffic, all
// checked every cycle against a frame-level reference model.
module tb_ser_word_rx;

  localparam int DW = 4;
`ifdef PARITY_CHK_EN
  localparam int FLEN = DW + 1;
`else
  localparam int FLEN = DW;
`endif

  logic clk;
  logic n_rst;

  ser_word_rx_if #(.DW(DW)) bus ();

  ser_word_rx #(.DW(DW)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: bits of the frame in progress and the held word.
  logic          frame[$];
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_fe, m_ov, m_pe;

  task automatic model_clear();
    frame.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_fe    = 1'b0;
    m_ov    = 1'b0;
    m_pe    = 1'b0;
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic cycle(input logic vld, input logic dat, input logic rdy, input string name);
    logic          done;
    logic [DW-1:0] word;
    int            ones;
    bus.ser_vld  = vld;
    bus.ser_data = dat;
    bus.rx_ready = rdy;
    done = 1'b0;
    word = '0;
    m_fe = 1'b0;
    m_ov = 1'b0;
    m_pe = 1'b0;
    if (vld) begin
      frame.push_back(dat);
      if (frame.size() == FLEN) begin
        ones = 0;
        for (int k = 0; k < FLEN; k++) ones += int'(frame[k]);
        for (int k = 0; k < DW; k++) word[k] = frame[k];
`ifdef PARITY_CHK_EN
        if (ones % 2 == 0) done = 1'b1;
        else               m_pe = 1'b1;
`else
        done = 1'b1;
`endif
        frame.delete();
      end
    end else if (frame.size() != 0) begin
      m_fe = 1'b1;
      frame.delete();
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_data  = word;
        m_valid = 1'b1;
      end else begin
        m_ov = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    vectors++;
    if ({bus.rx_data, bus.rx_valid, bus.frame_err, bus.overrun, bus.par_err} !==
        {m_data, m_valid, m_fe, m_ov, m_pe}) begin
      miscompares++;
      $display("FAIL %s @%0t: got data=%h valid=%b fe=%b ov=%b pe=%b, expected data=%h valid=%b fe=%b ov=%b pe=%b",
               name, $time, bus.rx_data, bus.rx_valid, bus.frame_err, bus.overrun, bus.par_err,
               m_data, m_valid, m_fe, m_ov, m_pe);
    end
  endtask

  task automatic send_word(input logic [DW-1:0] w, input logic rdy, input string name);
    for (int k = 0; k < DW; k++) cycle(1'b1, w[k], rdy, name);
`ifdef PARITY_CHK_EN
    cycle(1'b1, ^w, rdy, name);
`endif
  endtask

  // Asserts reset away from a clock edge and checks the outputs clear at once.
  task automatic apply_reset(input string name);
    n_rst        = 1'b0;
    bus.ser_vld  = 1'b0;
    bus.ser_data = 1'b0;
    bus.rx_ready = 1'b0;
    #2;
    model_clear();
    vectors++;
    if ({bus.rx_data, bus.rx_valid, bus.frame_err, bus.overrun, bus.par_err} !== '0) begin
      miscompares++;
      $display("FAIL %s: outputs during reset got data=%h valid=%b fe=%b ov=%b pe=%b, expected all 0",
               name, bus.rx_data, bus.rx_valid, bus.frame_err, bus.overrun, bus.par_err);
    end
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset("reset");
    cycle(1'b0, 1'b0, 1'b1, "reset_idle");
  endtask

  task automatic test_single();
    send_word(4'hD, 1'b1, "single");
    vectors++;
    if (bus.rx_data !== 4'hD || bus.rx_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL single_word: got data=%h valid=%b, expected data=d valid=1", bus.rx_data, bus.rx_valid);
    end
    cycle(1'b0, 1'b0, 1'b1, "single_drop");
    vectors++;
    if (bus.rx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_one_cycle: got valid=%b, expected 0", bus.rx_valid);
    end
  endtask

  task automatic test_back_to_back();
    send_word(4'hA, 1'b1, "b2b_first");
    send_word(4'h5, 1'b1, "b2b_second");
    cycle(1'b0, 1'b0, 1'b1, "b2b_tail");
  endtask

  task automatic test_short_frame();
    cycle(1'b1, 1'b1, 1'b1, "short_bit0");
    cycle(1'b1, 1'b0, 1'b1, "short_bit1");
    cycle(1'b0, 1'b0, 1'b1, "short_drop");
    vectors++;
    if (bus.frame_err !== 1'b1 || bus.rx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL short_frame_err: got fe=%b valid=%b, expected fe=1 valid=0", bus.frame_err, bus.rx_valid);
    end
    send_word(4'h6, 1'b1, "short_recover");
    cycle(1'b0, 1'b0, 1'b1, "short_tail");
  endtask

  task automatic test_overrun();
    send_word(4'h3, 1'b0, "ovr_first");
    send_word(4'hC, 1'b0, "ovr_second");
    vectors++;
    if (bus.overrun !== 1'b1 || bus.rx_data !== 4'h3) begin
      miscompares++;
      $display("FAIL overrun_pulse: got ov=%b data=%h, expected ov=1 data=3", bus.overrun, bus.rx_data);
    end
    cycle(1'b0, 1'b0, 1'b0, "ovr_hold");
    cycle(1'b0, 1'b0, 1'b1, "ovr_consume");
    vectors++;
    if (bus.rx_valid !== 1'b0 || bus.rx_data !== 4'h3) begin
      miscompares++;
      $display("FAIL overrun_consume: got valid=%b data=%h, expected valid=0 data=3", bus.rx_valid, bus.rx_data);
    end
  endtask

  task automatic test_reset_mid_frame();
    cycle(1'b1, 1'b0, 1'b1, "rst_mid_bit0");
    cycle(1'b1, 1'b1, 1'b1, "rst_mid_bit1");
    apply_reset("rst_mid");
    send_word(4'h9, 1'b1, "rst_mid_after");
    cycle(1'b0, 1'b0, 1'b1, "rst_mid_tail");
  endtask

`ifdef PARITY_CHK_EN
  task automatic test_parity();
    for (int k = 0; k < DW; k++) cycle(1'b1, (k < 3), 1'b1, "par_good");
    cycle(1'b1, 1'b1, 1'b1, "par_good_pbit");
    vectors++;
    if (bus.rx_data !== 4'h7 || bus.rx_valid !== 1'b1 || bus.par_err !== 1'b0) begin
      miscompares++;
      $display("FAIL parity_good: got data=%h valid=%b pe=%b, expected data=7 valid=1 pe=0",
               bus.rx_data, bus.rx_valid, bus.par_err);
    end
    for (int k = 0; k < DW; k++) cycle(1'b1, (k < 3), 1'b1, "par_bad");
    cycle(1'b1, 1'b0, 1'b1, "par_bad_pbit");
    vectors++;
    if (bus.par_err !== 1'b1 || bus.rx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL parity_bad: got pe=%b valid=%b, expected pe=1 valid=0", bus.par_err, bus.rx_valid);
    end
    cycle(1'b0, 1'b0, 1'b1, "par_tail");
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 2000; n++) begin
      cycle(($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom), "random");
    end
  endtask

  initial begin
    n_rst        = 1'b0;
    bus.ser_vld  = 1'b0;
    bus.ser_data = 1'b0;
    bus.rx_ready = 1'b0;
    model_clear();
    test_reset();
    test_single();
    test_back_to_back();
    test_short_frame();
    test_overrun();
    test_reset_mid_frame();
`ifdef PARITY_CHK_EN
    test_parity();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
